// File: rtl/bcd_counter_pkg.sv
// bcd_counter_scan shared package: digit width, segment codes, helpers.
// Segment codes are gfedcba, active-low.
package bcd_counter_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [6:0] seg_enc(
    input logic [BCD_W-1:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_counter_scan_if.sv
// bcd_counter_scan control/display bundle.
// master = board controls side, slave = counter.
interface bcd_counter_scan_if #(
  parameter int NUM_DIGITS = 3
);
  import bcd_counter_pkg::*;

  logic                        en;
  logic                        up_dn;
  logic                        clr;
  logic                        load;
  logic [BCD_W*NUM_DIGITS-1:0] load_val;
  logic [BCD_W*NUM_DIGITS-1:0] count_bcd;
  logic                        tick;
  logic                        wrap;
  logic [6:0]                  seg;
  logic [NUM_DIGITS-1:0]       an;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  count_bcd, tick, wrap, seg, an
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output count_bcd, tick, wrap, seg, an
  );

endinterface

// File: rtl/bcd_digit.sv
// bcd_counter_scan single BCD cell with clamped load.
// o_step: this digit rolls over, so the next digit must step.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_step,
  input  logic             i_up_dn,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [BCD_W-1:0] i_load_nib,
  output logic [BCD_W-1:0] o_val,
  output logic             o_step
);

  logic [BCD_W-1:0] r_val;
  logic [BCD_W-1:0] w_nib;
  logic             w_at_max;
  logic             w_at_min;

  assign w_nib    = (i_load_nib > 4'd9) ? 4'd9 : i_load_nib;
  assign w_at_max = (r_val == 4'd9);
  assign w_at_min = (r_val == 4'd0);
  assign o_step   = i_step &
                    (i_up_dn ? w_at_max : w_at_min);
  assign o_val    = r_val;

  // digit register: clear, then load, then step
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_val <= '0;
    end else begin
      priority case (1'b1)
        i_clr:  r_val <= '0;
        i_load: r_val <= w_nib;
        i_step: begin
          if (i_up_dn)
            r_val <= w_at_max ? 4'd0 : r_val + 4'd1;
          else
            r_val <= w_at_min ? 4'd9 : r_val - 4'd1;
        end
        default: r_val <= r_val;
      endcase
    end
  end

endmodule

// File: rtl/bcd_counter_scan.sv
// bcd_counter_scan: N-digit BCD up/down counter, muxed 7-seg.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_counter_scan
  import bcd_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TICK_HZ    = 4,
  parameter int SCAN_BITS  = 20
) (
  input logic              clk,
  input logic              rst_n,
  bcd_counter_scan_if.slave bus
);

  localparam int MAX_TICK = CLK_FREQ / TICK_HZ;
  localparam int PW =
    (clog2(MAX_TICK) < 1) ? 1 : clog2(MAX_TICK);
  localparam int DSEL_W =
    (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);
  localparam int CW = BCD_W * NUM_DIGITS;
  localparam logic [PW-1:0] TICK_LAST = PW'(MAX_TICK - 1);

  logic [PW-1:0]         r_presc;
  logic                  r_tick;
  logic                  r_wrap;
  logic [SCAN_BITS-1:0]  r_scan;
  logic [DSEL_W-1:0]     w_sel;
  logic [NUM_DIGITS:0]   w_step;
  logic [CW-1:0]         w_count;
  logic [NUM_DIGITS-1:0] w_an;
  logic [6:0]            w_seg;
  logic                  w_last;

  assign w_last = (r_presc == TICK_LAST);

  // prescaler: tick follows the last prescaler count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= w_last;
      r_presc <= w_last ? '0 : r_presc + 1'b1;
    end
  end

  assign w_step[0] = r_tick & bus.en;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      bcd_digit u_digit (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_step     (w_step[g]),
        .i_up_dn    (bus.up_dn),
        .i_load     (bus.load),
        .i_clr      (bus.clr),
        .i_load_nib (bus.load_val[g*BCD_W +: BCD_W]),
        .o_val      (w_count[g*BCD_W +: BCD_W]),
        .o_step     (w_step[g+1])
      );
    end
  endgenerate

  // wrap: top digit rolled over on a real step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wrap <= 1'b0;
    else
      r_wrap <= w_step[NUM_DIGITS] & ~bus.clr & ~bus.load;
  end

  // free-running scan counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_scan <= '0;
    else
      r_scan <= r_scan + 1'b1;
  end

  assign w_sel = r_scan[SCAN_BITS-1 -: DSEL_W];

  // anode/segment mux for the selected digit
  always_comb begin
    logic [BCD_W-1:0] dig;
`ifdef LEADING_ZERO_BLANK_EN
    logic hz;
    hz = 1'b1;
`endif
    w_an  = '1;
    w_seg = SEG_BLANK;
    dig   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      dig = w_count[i*BCD_W +: BCD_W];
`ifdef LEADING_ZERO_BLANK_EN
      hz = hz & (dig == 4'd0);
`endif
      if (int'(w_sel) == i) begin
        w_an[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        w_seg = (i > 0 && hz) ? SEG_BLANK : seg_enc(dig);
`else
        w_seg = seg_enc(dig);
`endif
      end
    end
  end

  assign bus.count_bcd = w_count;
  assign bus.tick      = r_tick;
  assign bus.wrap      = r_wrap;
  assign bus.an        = w_an;
  assign bus.seg       = w_seg;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// bcd_counter_scan directed bench.
// MAX_TICK = 10, SCAN_BITS = 4, three digits.
`timescale 1ns/1ps
module tb_bcd_counter_scan;

  localparam int ND = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] tb_scan = '0;

  bcd_counter_scan_if #(.NUM_DIGITS(ND)) bus ();

  bcd_counter_scan #(
    .NUM_DIGITS (ND),
    .CLK_FREQ   (40),
    .TICK_HZ    (4),
    .SCAN_BITS  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_scan <= '0;
    else        tb_scan <= tb_scan + 4'd1;

  task automatic step_ticks(
    input  int n,
    output int wraps,
    output int bad
  );
    int cyc;
    wraps = 0;
    bad   = 0;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (bus.wrap === 1'b1) wraps++;
      end while (bus.tick !== 1'b1 && cyc < 40);
      if (bus.tick !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL tick_timeout got %0d cycles exp tick", cyc);
      end else if (i > 0 && cyc != 10) begin
        bad++;
      end
    end
    @(negedge clk);
    if (bus.wrap === 1'b1) wraps++;
  endtask

  task automatic load_val(input logic [11:0] v);
    bus.load_val = v;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    bus.en = 0; bus.up_dn = 1; bus.clr = 0;
    bus.load = 0; bus.load_val = '0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.count_bcd !== 12'h000 || bus.tick !== 1'b0 ||
        bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got %h/%b/%b exp 000/0/0",
               bus.count_bcd, bus.tick, bus.wrap);
    end
    checks++;
    if (bus.an !== 3'b110 || bus.seg !== 7'h40) begin
      errors++;
      $display("FAIL reset_disp got %b/%h exp 110/40",
               bus.an, bus.seg);
    end
    rst_n = 1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.tick !== 1'b1 && cyc < 40);
    checks++;
    if (cyc != 10) begin
      errors++;
      $display("FAIL first_tick got %0d exp 10", cyc);
    end
  endtask

  task automatic test_count_up();
    int w, b;
    @(negedge clk);
    bus.en = 1; bus.up_dn = 1;
    step_ticks(25, w, b);
    checks++;
    if (bus.count_bcd !== 12'h025) begin
      errors++;
      $display("FAIL up25 got %h exp 025", bus.count_bcd);
    end
    checks++;
    if (b != 0) begin
      errors++;
      $display("FAIL tick_period got %0d bad exp 0", b);
    end
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL up_nowrap got %0d exp 0", w);
    end
  endtask

  task automatic test_load_wrap();
    int w, b;
    load_val(12'h998);
    checks++;
    if (bus.count_bcd !== 12'h998) begin
      errors++;
      $display("FAIL load998 got %h exp 998", bus.count_bcd);
    end
    step_ticks(1, w, b);
    checks++;
    if (bus.count_bcd !== 12'h999 || w != 0) begin
      errors++;
      $display("FAIL up999 got %h/%0d exp 999/0",
               bus.count_bcd, w);
    end
    step_ticks(1, w, b);
    checks++;
    if (bus.count_bcd !== 12'h000 || bus.wrap !== 1'b1) begin
      errors++;
      $display("FAIL upwrap got %h/%b exp 000/1",
               bus.count_bcd, bus.wrap);
    end
    @(negedge clk);
    checks++;
    if (bus.wrap !== 1'b0 || w != 1) begin
      errors++;
      $display("FAIL wrap_width got %b/%0d exp 0/1",
               bus.wrap, w);
    end
    load_val(12'hAF3);
    checks++;
    if (bus.count_bcd !== 12'h993) begin
      errors++;
      $display("FAIL clamp got %h exp 993", bus.count_bcd);
    end
  endtask

  task automatic test_down();
    int w, b;
    load_val(12'h100);
    bus.up_dn = 0;
    step_ticks(1, w, b);
    checks++;
    if (bus.count_bcd !== 12'h099 || w != 0) begin
      errors++;
      $display("FAIL down099 got %h/%0d exp 099/0",
               bus.count_bcd, w);
    end
    bus.clr = 1;
    @(negedge clk);
    bus.clr = 0;
    checks++;
    if (bus.count_bcd !== 12'h000 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL clr got %h/%b exp 000/0",
               bus.count_bcd, bus.wrap);
    end
    step_ticks(1, w, b);
    checks++;
    if (bus.count_bcd !== 12'h999 || w != 1) begin
      errors++;
      $display("FAIL downwrap got %h/%0d exp 999/1",
               bus.count_bcd, w);
    end
  endtask

  task automatic test_clr_load_tick();
    int w, b, cyc;
    bus.up_dn = 1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.tick !== 1'b1 && cyc < 40);
    bus.clr = 1; bus.load = 1; bus.load_val = 12'h123;
    @(negedge clk);
    bus.clr = 0; bus.load = 0;
    checks++;
    if (bus.count_bcd !== 12'h000 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL clr_prio got %h/%b exp 000/0",
               bus.count_bcd, bus.wrap);
    end
    load_val(12'h321);
    bus.en = 0;
    step_ticks(5, w, b);
    checks++;
    if (bus.count_bcd !== 12'h321 || w != 0) begin
      errors++;
      $display("FAIL hold got %h/%0d exp 321/0",
               bus.count_bcd, w);
    end
  endtask

  task automatic test_scan();
    logic [1:0] sel;
    logic [2:0] ean;
    logic [6:0] eseg;
    load_val(12'h047);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      sel = tb_scan[3:2];
      case (sel)
        2'd0: begin ean = 3'b110; eseg = 7'h78; end
        2'd1: begin ean = 3'b101; eseg = 7'h19; end
`ifdef LEADING_ZERO_BLANK_EN
        2'd2: begin ean = 3'b011; eseg = 7'h7F; end
`else
        2'd2: begin ean = 3'b011; eseg = 7'h40; end
`endif
        default: begin ean = 3'b111; eseg = 7'h7F; end
      endcase
      checks++;
      if (bus.an !== ean || bus.seg !== eseg) begin
        errors++;
        $display("FAIL scan_sel%0d got %b/%h exp %b/%h",
                 sel, bus.an, bus.seg, ean, eseg);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    load_val(12'h573);
    checks++;
    if (bus.count_bcd !== 12'h573) begin
      errors++;
      $display("FAIL load573 got %h exp 573", bus.count_bcd);
    end
    bus.en = 1; bus.up_dn = 1;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (bus.count_bcd !== 12'h000 || bus.tick !== 1'b0 ||
        bus.wrap !== 1'b0 || bus.an !== 3'b110 ||
        bus.seg !== 7'h40) begin
      errors++;
      $display("FAIL async_rst got %h/%b/%b/%b/%h exp 000/0/0/110/40",
               bus.count_bcd, bus.tick, bus.wrap,
               bus.an, bus.seg);
    end
    @(negedge clk);
    rst_n = 1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.tick !== 1'b1 && cyc < 40);
    checks++;
    if (cyc != 10) begin
      errors++;
      $display("FAIL rst_tick got %0d exp 10", cyc);
    end
    @(negedge clk);
    checks++;
    if (bus.count_bcd !== 12'h001 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL rst_count got %h/%b exp 001/0",
               bus.count_bcd, bus.wrap);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_load_wrap();
    test_down();
    test_clr_load_tick();
    test_scan();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
